// File: rtl/cache_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cache_mem_arbiter
// Brief    : Round-robin line arbiter sharing one memory port between I$ and D$
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
  parameter int LINE_WIDTH  = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY_I = 3'd1,
    S_BUSY_D = 3'd2,
    S_DONE_I = 3'd3,
    S_DONE_D = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_last_d;
  logic                  r_op_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;

  logic                  w_i_req;
  logic                  w_d_req;
  logic                  w_grant_d;
  logic [ADDR_WIDTH-1:0] w_i_line;
  logic [ADDR_WIDTH-1:0] w_d_line;
  logic                  w_unused;

  assign w_i_req   = i_read;
  assign w_d_req   = d_read | d_write;
  // On a tie the side that did not win last time is served.
  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);
  assign w_i_line  = {i_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign w_d_line  = {d_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign w_unused  = ^{i_address[OFFSET_BITS-1:0], d_address[OFFSET_BITS-1:0]};

  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_d   <= 1'b0;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      i_resp     <= 1'b0;
      d_resp     <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state    <= S_BUSY_D;
            r_last_d   <= 1'b1;
            r_addr     <= w_d_line;
            r_wdata    <= d_wdata;
            r_op_write <= d_write;
            pmem_read  <= ~d_write;
            pmem_write <= d_write;
          end else if (w_i_req) begin
            r_state    <= S_BUSY_I;
            r_last_d   <= 1'b0;
            r_addr     <= w_i_line;
            r_op_write <= 1'b0;
            pmem_read  <= 1'b1;
            pmem_write <= 1'b0;
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            if (r_state == S_BUSY_I) begin
              r_state <= S_DONE_I;
              i_resp  <= 1'b1;
              if (!r_op_write) i_rdata <= pmem_rdata;
            end else begin
              r_state <= S_DONE_D;
              d_resp  <= 1'b1;
              if (!r_op_write) d_rdata <= pmem_rdata;
            end
          end
        end
        S_DONE_I, S_DONE_D: begin
          i_resp  <= 1'b0;
          d_resp  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
